// File: rtl/ram16_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : ram16_stream_writer
// Description : Write-side master for the 16-bit simulation RAM. Splits each
//               32-bit stream word into two halfwords (low half first), writes
//               them to consecutive RAM addresses from a programmed base for a
//               programmed halfword count, then issues one read-enable cycle
//               so the RAM's parallel read registers refresh, and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module ram16_stream_writer #(
    parameter int MEM_WIDTH  = 65536,
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_W     = $clog2(MEM_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   count_i,
    input  logic              s_valid_i,
    input  logic [31:0]       s_data_i,
    output logic              s_ready_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   written_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_WR_LO     = 3'd2,
        S_WR_HI     = 3'd3,
        S_SNAP      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MEM_WIDTH - 1);
    localparam logic [ADDR_W:0]   c_ONE_CNT   = (ADDR_W+1)'(1);

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   cur_addr_q,  cur_addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [ADDR_W:0]     written_q,   written_d;
    logic [31:0]         word_q,      word_d;

    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_write;

    // Address increment wraps explicitly so non-power-of-two depths also wrap to 0.
    assign w_next_addr = (cur_addr_q == c_LAST_ADDR) ? '0 : cur_addr_q + ADDR_W'(1);

    // State and datapath registers; reset abandons any transfer in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            written_q   <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            written_q   <= written_d;
            word_q      <= word_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        written_d   = written_q;
        word_d      = word_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    written_d = '0;
                    if (count_i != '0) begin
                        cur_addr_d  = base_addr_i;
                        remaining_d = count_i;
                        state_d     = S_WAIT_WORD;
                    end else begin
                        // Zero-length transfer: no RAM traffic, just report done.
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT_WORD: begin
                // Ready is high throughout this state, so valid alone completes the handshake.
                if (s_valid_i) begin
                    word_d  = s_data_i;
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO, S_WR_HI: begin
                cur_addr_d  = w_next_addr;
                remaining_d = remaining_q - c_ONE_CNT;
                written_d   = written_q + c_ONE_CNT;
                if (remaining_q == c_ONE_CNT) begin
                    // Final halfword; with an odd count the upper half is dropped here.
                    state_d = S_SNAP;
                end else if (state_q == S_WR_LO) begin
                    state_d = S_WR_HI;
                end else begin
                    state_d = S_WAIT_WORD;
                end
            end
            S_SNAP: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_write = (state_q == S_WR_LO) || (state_q == S_WR_HI);

    // Output decode purely from registered state, so no input reaches an output combinationally.
    always_comb begin
        s_ready_o  = (state_q == S_WAIT_WORD);
        mem_en_o   = w_write || (state_q == S_SNAP);
        mem_we_o   = w_write;
        mem_addr_o = (w_write || (state_q == S_SNAP)) ? cur_addr_q : '0;
        mem_data_o = '0;
        if (state_q == S_WR_LO) begin
            mem_data_o = {{(32-WORD_WIDTH){1'b0}}, word_q[WORD_WIDTH-1:0]};
        end else if (state_q == S_WR_HI) begin
            mem_data_o = {{(32-WORD_WIDTH){1'b0}}, word_q[2*WORD_WIDTH-1:WORD_WIDTH]};
        end
        busy_o    = (state_q != S_IDLE);
        done_o    = (state_q == S_DONE);
        written_o = written_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram16_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram16_stream_writer
// Description : Directed bench for ram16_stream_writer. Expected RAM writes are
//               queued as stimulus is driven and popped as the DUT writes; a
//               behavioural RAM records the writes for read-back checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram16_stream_writer;

    localparam int ADDR_W = 16;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W:0]   count_i;
    logic              s_valid_i;
    logic [31:0]       s_data_i;
    logic              s_ready_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W:0]   written_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected writes: {addr[15:0], data[31:0]}
    logic [47:0] exp_q[$];
    logic [15:0] ram [0:65535];

    ram16_stream_writer #(
        .MEM_WIDTH  (65536),
        .WORD_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .s_ready_o   (s_ready_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .written_o   (written_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [15:0] addr, input logic [15:0] hw);
        exp_q.push_back({addr, 16'h0000, hw});
    endtask

    // Scoreboard: every RAM write observed mid-cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (mem_en_o === 1'b1 && mem_we_o === 1'b1) begin
            logic [47:0] exp_w;
            n_cmp++;
            if (exp_q.size() == 0) begin
                exp_w = 48'hFFFF_FFFF_FFFF;
                n_fail++;
                $error("FAIL unexpected_write: observed %0h expected no write",
                       {mem_addr_o, mem_data_o});
            end else begin
                exp_w = exp_q.pop_front();
                assert ({mem_addr_o, mem_data_o} === exp_w) else begin
                    n_fail++;
                    $error("FAIL ram_write: observed %0h expected %0h",
                           {mem_addr_o, mem_data_o}, exp_w);
                end
            end
            ram[mem_addr_o] = mem_data_o[15:0];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        rst = 1'b0; start_i = 1'b0; base_addr_i = '0; count_i = '0;
        s_valid_i = 1'b0; s_data_i = '0;

        // ---------------- reset values ----------------
        repeat (3) tick();
        check("rst_ready", s_ready_o, 0);
        check("rst_en", mem_en_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_data", mem_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_written", written_o, 0);
        rst = 1'b1;
        tick();
        check("idle_busy", busy_o, 0);
        check("idle_ready", s_ready_o, 0);

        // ---------------- basic even transfer ----------------
        exp_push(16'h0010, 16'hAAAA); exp_push(16'h0011, 16'hBBBB);
        exp_push(16'h0012, 16'hCCCC); exp_push(16'h0013, 16'hDDDD);
        base_addr_i = 16'h0010; count_i = 17'd4; start_i = 1'b1;
        s_valid_i = 1'b1; s_data_i = 32'hBBBB_AAAA;
        tick();                                   // WAIT_WORD
        start_i = 1'b0;
        check("ev_ready", s_ready_o, 1);
        check("ev_busy", busy_o, 1);
        check("ev_written_clr", written_o, 0);
        tick();                                   // WR_LO
        s_data_i = 32'hDDDD_CCCC;
        check("ev_lo_addr", mem_addr_o, 16'h0010);
        check("ev_lo_ready", s_ready_o, 0);
        tick();                                   // WR_HI
        check("ev_hi_data", mem_data_o, 32'h0000_BBBB);
        tick();                                   // WAIT_WORD
        check("ev_ready2", s_ready_o, 1);
        tick();                                   // WR_LO
        s_valid_i = 1'b0;
        tick();                                   // WR_HI
        tick();                                   // SNAP
        check("ev_snap_en", mem_en_o, 1);
        check("ev_snap_we", mem_we_o, 0);
        check("ev_snap_addr", mem_addr_o, 16'h0014);
        check("ev_snap_data", mem_data_o, 0);
        tick();                                   // DONE
        check("ev_done", done_o, 1);
        check("ev_written", written_o, 4);
        tick();                                   // IDLE
        check("ev_done_clr", done_o, 0);
        check("ev_idle_busy", busy_o, 0);
        check("ev_written_hold", written_o, 4);
        check("ev_ram16", ram[16], 16'hAAAA);
        check("ev_ram17", ram[17], 16'hBBBB);
        check("ev_ram18", ram[18], 16'hCCCC);
        check("ev_ram19", ram[19], 16'hDDDD);

        // ---------------- odd count with backpressure ----------------
        exp_push(16'h0000, 16'h1111); exp_push(16'h0001, 16'h2222);
        exp_push(16'h0002, 16'h3333);
        base_addr_i = 16'h0000; count_i = 17'd3; start_i = 1'b1;
        s_valid_i = 1'b1; s_data_i = 32'h2222_1111;
        tick();                                   // WAIT_WORD
        start_i = 1'b0;
        tick();                                   // WR_LO
        s_valid_i = 1'b0;
        tick();                                   // WR_HI
        tick();                                   // WAIT_WORD
        for (int i = 0; i < 5; i++) begin
            check("odd_gap_ready", s_ready_o, 1);
            tick();
        end
        s_valid_i = 1'b1; s_data_i = 32'h4444_3333;
        tick();                                   // WR_LO
        s_valid_i = 1'b0;
        check("odd_lo_addr", mem_addr_o, 16'h0002);
        tick();                                   // SNAP
        check("odd_snap_we", mem_we_o, 0);
        check("odd_snap_addr", mem_addr_o, 16'h0003);
        tick();                                   // DONE
        check("odd_done", done_o, 1);
        check("odd_written", written_o, 3);
        tick();
        check("odd_ram2", ram[2], 16'h3333);
        check("odd_ram3", ram[3], 16'h0000);

        // ---------------- address wrap ----------------
        exp_push(16'hFFFF, 16'h1234); exp_push(16'h0000, 16'h5678);
        base_addr_i = 16'hFFFF; count_i = 17'd2; start_i = 1'b1;
        s_valid_i = 1'b1; s_data_i = 32'h5678_1234;
        tick();                                   // WAIT_WORD
        start_i = 1'b0;
        tick();                                   // WR_LO
        s_valid_i = 1'b0;
        check("wrap_lo_addr", mem_addr_o, 16'hFFFF);
        tick();                                   // WR_HI
        check("wrap_hi_addr", mem_addr_o, 16'h0000);
        tick();                                   // SNAP
        check("wrap_snap_addr", mem_addr_o, 16'h0001);
        tick();                                   // DONE
        check("wrap_done", done_o, 1);
        check("wrap_written", written_o, 2);
        tick();
        check("wrap_ramFFFF", ram[16'hFFFF], 16'h1234);
        check("wrap_ram0", ram[0], 16'h5678);

        // ---------------- zero count ----------------
        base_addr_i = 16'h0040; count_i = 17'd0; start_i = 1'b1;
        tick();                                   // DONE
        start_i = 1'b0;
        check("zero_done", done_o, 1);
        check("zero_en", mem_en_o, 0);
        tick();                                   // IDLE
        check("zero_done_clr", done_o, 0);
        check("zero_en2", mem_en_o, 0);
        check("zero_busy", busy_o, 0);

        // ---------------- ignored start and reset mid-transfer ----------------
        exp_push(16'h0100, 16'h4321);
        base_addr_i = 16'h0100; count_i = 17'd4; start_i = 1'b1;
        tick();                                   // WAIT_WORD
        base_addr_i = 16'h0200; count_i = 17'd1;  // must be ignored while busy
        tick();                                   // still WAIT_WORD
        start_i = 1'b0;
        check("ign_busy", busy_o, 1);
        s_valid_i = 1'b1; s_data_i = 32'h8765_4321;
        tick();                                   // WR_LO
        s_valid_i = 1'b0;
        check("ign_lo_addr", mem_addr_o, 16'h0100);
        tick();                                   // WR_HI (count 4 kept, so no SNAP)
        check("ign_hi_we", mem_we_o, 1);
        check("ign_hi_addr", mem_addr_o, 16'h0101);
        rst = 1'b0;
        #1;
        check("mrst_en", mem_en_o, 0);
        check("mrst_we", mem_we_o, 0);
        check("mrst_addr", mem_addr_o, 0);
        check("mrst_data", mem_data_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_written", written_o, 0);
        repeat (2) begin
            tick();
            check("mrst_hold_en", mem_en_o, 0);
        end
        rst = 1'b1;
        repeat (2) begin
            tick();
            check("post_rst_en", mem_en_o, 0);
            check("post_rst_busy", busy_o, 0);
        end
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
